// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX memory-access path.
//   MOP_* : MemOP size encodings driven by the control unit.
//   mem_state_e : state encoding of the memory-access controller.
//   mop_fault() : alignment/legality check for a requested access.
package dlx_pkg;

  localparam logic [1:0] MOP_WORD = 2'b00;
  localparam logic [1:0] MOP_HALF = 2'b01;
  localparam logic [1:0] MOP_BYTE = 2'b10;
  localparam logic [1:0] MOP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } mem_state_e;

  // True when the size encoding is illegal or the byte offset is not
  // naturally aligned for that size.
  function automatic logic mop_fault(logic [1:0] op, logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (op)
      MOP_WORD: bad = |offset;
      MOP_HALF: bad = offset[0];
      MOP_BYTE: bad = 1'b0;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dlx_mem_lane.sv
// Big-endian lane steering for the DLX memory path (purely combinational).
//   mem_op     : access size (MOP_WORD / MOP_HALF / MOP_BYTE)
//   mem_signed : 1 = sign-extend narrow loads, 0 = zero-extend
//   offset     : byte offset within the word (addr[1:0])
//   st_data    : right-justified store data
//   ld_raw     : raw 32-bit word returned by memory
//   be         : byte enables, bit 3 covers bits 31:24
//   st_lane    : store data replicated into every lane of its size
//   ld_data    : load data extracted from the selected lane and extended
module dlx_mem_lane
  import dlx_pkg::*;
(
  input  logic [1:0]  mem_op,
  input  logic        mem_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lane,
  output logic [31:0] ld_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    be       = 4'b0000;
    st_lane  = 32'h0;
    ld_data  = 32'h0;
    half_sel = 16'h0;
    byte_sel = 8'h0;
    case (mem_op)
      MOP_WORD: begin
        be      = 4'b1111;
        st_lane = st_data;
        ld_data = ld_raw;
      end
      MOP_HALF: begin
        // Offset 0 is the most significant halfword (big-endian).
        be       = offset[1] ? 4'b0011 : 4'b1100;
        half_sel = offset[1] ? ld_raw[15:0] : ld_raw[31:16];
        st_lane  = {2{st_data[15:0]}};
        ld_data  = {{16{mem_signed & half_sel[15]}}, half_sel};
      end
      MOP_BYTE: begin
        be = 4'b1000 >> offset;
        case (offset)
          2'd0:    byte_sel = ld_raw[31:24];
          2'd1:    byte_sel = ld_raw[23:16];
          2'd2:    byte_sel = ld_raw[15:8];
          default: byte_sel = ld_raw[7:0];
        endcase
        st_lane = {4{st_data[7:0]}};
        ld_data = {{24{mem_signed & byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dlx_mem_ctrl.sv
// Memory-access controller between the DLX control unit and a single-port,
// fixed-latency synchronous memory. One access per request; MemWait holds the
// control unit while the access is in flight.
//   clock, Reset        : system clock, asynchronous active-high reset
//   MemRead, MemWrite   : level request from the control unit
//   MemOP, MemSigned    : access size and load extension mode
//   addr, wdata         : byte address (low AW bits used), right-justified data
//   MemWait             : control unit must hold its stage
//   rdata               : extended load data, valid from the DONE cycle
//   MemFault            : one-cycle pulse for misaligned/illegal requests
//   mem_*               : memory-side enable, write enable, word address,
//                         byte enables, steered write data, read data
module dlx_mem_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = 16
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    MemOP,
  input  logic          MemSigned,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          MemWait,
  output logic [31:0]   rdata,
  output logic          MemFault,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0] WcntInit = 4'(WAIT_STATES - 1);

  mem_state_e    state_q;
  logic [3:0]    wcnt_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    op_q;
  logic          sgn_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic        in_idle;
  logic        req;
  logic        fault;
  logic        accept;
  logic [1:0]  lane_op;
  logic        lane_sgn;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_st;
  logic [31:0] lane_ld;

  // Upper address bits are outside the memory window.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];

  assign in_idle = (state_q == StIdle);
  assign req     = MemRead | MemWrite;
  assign fault   = (MemRead & MemWrite) | mop_fault(MemOP, addr[1:0]);
  assign accept  = in_idle & req & ~fault;

  // The single lane unit steers the incoming request while idle and extracts
  // load data from the latched request once the access is under way.
  assign lane_op  = in_idle ? MemOP     : op_q;
  assign lane_sgn = in_idle ? MemSigned : sgn_q;
  assign lane_off = in_idle ? addr[1:0] : addr_q[1:0];

  dlx_mem_lane u_lane (
    .mem_op     (lane_op),
    .mem_signed (lane_sgn),
    .offset     (lane_off),
    .st_data    (wdata),
    .ld_raw     (mem_rdata),
    .be         (lane_be),
    .st_lane    (lane_st),
    .ld_data    (lane_ld)
  );

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      op_q    <= MOP_WORD;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= addr[AW-1:0];
            op_q    <= MemOP;
            sgn_q   <= MemSigned;
            we_q    <= MemWrite;
            be_q    <= lane_be;
            wdata_q <= lane_st;
            wcnt_q  <= WcntInit;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (wcnt_q == 4'd0) begin
            if (!we_q) rdata_q <= lane_ld;
            state_q <= StDone;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        // A request still held here is the one just completed.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by Reset so the control unit is released as soon as reset hits,
  // even if it keeps its request asserted.
  assign MemWait  = ~Reset & (accept | (state_q == StAccess));
  assign MemFault = ~Reset & in_idle & req & fault;

  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & we_q;
  assign mem_be    = mem_en ? be_q : 4'b0000;
  assign mem_addr  = addr_q[AW-1:2];
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/dlx_mem_ctrl.md
# dlx_mem_ctrl

Memory-access controller between the non-pipelined DLX control unit/datapath and a single-port, fixed-latency synchronous memory. Accepts one read or write per request, drives the memory with stable address/byte-enables/data for a programmable number of wait states, and holds `MemWait` high so the control unit freezes its stage until the access completes. Performs big-endian byte/halfword lane steering and sign/zero extension, and flags misaligned or illegal requests without touching memory.

## Interface
- `WAIT_STATES`, 2, memory cycles per access (legal 1..15)
- `AW`, 16, memory byte-address width (word address is `AW-2` bits)
- `clock`  in  1  system clock
- `Reset`  in  1  asynchronous, active-high reset
- `MemRead`  in  1  read request from control unit (level)
- `MemWrite`  in  1  write request from control unit (level)
- `MemOP`  in  2  size: 00 word, 01 halfword, 10 byte, 11 illegal
- `MemSigned`  in  1  1 = sign-extend byte/halfword reads, 0 = zero-extend
- `addr`  in  32  byte address from MAR; only `addr[AW-1:0]` is used
- `wdata`  in  32  store data from MDR, right-justified
- `MemWait`  out  1  high = control unit must hold its stage
- `rdata`  out  32  extended load data to MDR, valid in the DONE cycle
- `MemFault`  out  1  one-cycle pulse on misaligned/illegal request
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW-2  word address
- `mem_be`  out  4  byte enables, bit 3 = bits 31:24
- `mem_wdata`  out  32  lane-steered store data
- `mem_rdata`  in  32  memory read data, valid in the last ACCESS cycle

## Operation
- States: IDLE, ACCESS, DONE. Wait counter `wcnt`, 4 bits.
- IDLE: `req = MemRead | MemWrite`. Fault if both asserted, `MemOP==11`, halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `req` and fault: `MemFault`=1 for this cycle, `MemWait`=0, stay IDLE, no memory access.
  - `req` and no fault: latch `addr`, `MemOP`, `MemSigned`, `MemWrite`, and steered `wdata`; `wcnt`←`WAIT_STATES-1`; go to ACCESS. `MemWait`=1 combinationally in this cycle.
- ACCESS: `mem_en`=1; `mem_we`, `mem_addr`, `mem_be`, and `mem_wdata` are driven from latched values and are stable throughout. `MemWait`=1. When `wcnt`==0, register extended `mem_rdata` into `rdata` and go to DONE; otherwise decrement `wcnt`.
- DONE: `MemWait`=0, `mem_en`=0, `rdata` valid. Always return to IDLE. A request still asserted in this cycle is the completing request, not a new one.
- Lanes (big-endian): word → be 1111. Halfword at offset 0 → 1100, offset 2 → 0011. Byte at offset k → bit 3-k. Store data is replicated into the selected lane(s). Load data is extracted from the same lane(s), then extended per `MemSigned`.
- `rdata` holds its value until the next completed read. Writes leave `rdata` unchanged.

## Timing
- Request in cycle 0 (IDLE). ACCESS occupies cycles 1..`WAIT_STATES`. DONE is cycle `WAIT_STATES`+1.
- `MemWait` is high in cycles 0..`WAIT_STATES`, so total latency is `WAIT_STATES`+2 cycles.
- Reset values: state IDLE, `MemWait` 0, `MemFault` 0, `mem_en` 0, `mem_we` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0, `rdata` 0, `wcnt` 0.
- Reset asserted mid-access: `mem_en`/`mem_we` drop immediately (asynchronous), and the access is abandoned.
- Request inputs are ignored outside IDLE. Changes to `addr`/`wdata` during ACCESS have no effect.

## Structure
- Shared package `dlx_pkg`:
  - MemOP encodings `MOP_WORD`/`MOP_HALF`/`MOP_BYTE`
  - state encoding
- Sub-module `dlx_mem_lane`: combinational store steering, byte-enable generation, load extraction/extension. Instantiated once.

## Test plan
- Word read, `WAIT_STATES`=2, addr 0x0010, memory word 0x11223344 → `MemWait` high 3 cycles, `mem_addr`=0x0004, `mem_be`=1111, `rdata`=0x11223344 in DONE.
- Signed byte read at 0x0013 with memory word 0x000000F0 → `mem_be`=0001, `rdata`=0xFFFFFFF0. Unsigned → 0x000000F0.
- Halfword write 0xABCD to 0x0022 → `mem_we`=1, `mem_be`=0011, `mem_wdata`=0xABCDABCD for 2 cycles, `rdata` unchanged.
- Word read at 0x0002, then `MemRead`+`MemWrite` together, then `MemOP`=11 → each produces a 1-cycle `MemFault`, `MemWait` 0, `mem_en` never asserted.
- Assert `Reset` in the first ACCESS cycle → `mem_en`/`MemWait` low immediately, state IDLE. A new request after release completes normally.
- Back-to-back: read completes, next request arrives in the cycle after DONE → accepted from IDLE with the same `WAIT_STATES`+2 latency.
